// File: rtl/rf_sequencer.sv
// rf_sequencer: sequences WRITE/READ/MOVE/SWAP commands onto an 8-entry
// register file (R1-R4, S1-S4) through load-only write enables and two read ports.
// All outputs are registered. They are computed from the next state, so every
// output changes on the same edge as the state it belongs to.
module rf_sequencer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [2:0]  i_cmd_src,
  input  logic [2:0]  i_cmd_dst,
  input  logic [31:0] i_cmd_data,
  output logic        o_done,
  output logic [31:0] o_rd_data,
  output logic [31:0] o_i,
  output logic [2:0]  o_out_a_sel,
  output logic [2:0]  o_out_b_sel,
  output logic [2:0]  o_fun_sel,
  output logic [3:0]  o_reg_sel,
  output logic [3:0]  o_scr_sel,
  input  logic [31:0] i_out_a,
  input  logic [31:0] i_out_b
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned EN_W   = 8;

  localparam logic [1:0]        OP_WRITE = 2'b00;
  localparam logic [1:0]        OP_READ  = 2'b01;
  localparam logic [1:0]        OP_MOVE  = 2'b10;
  localparam logic [1:0]        OP_SWAP  = 2'b11;
  localparam logic [CODE_W-1:0] FUN_LOAD = 3'b010;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_A, S_WR_B, S_FIN} state_t;

  state_t              r_state, w_state_next;
  logic [1:0]          r_op;
  logic [CODE_W-1:0]   r_src, r_dst;
  logic [DATA_W-1:0]   r_data, r_hold_a, r_hold_b, r_rd_data;
  logic                r_cmd_ready, r_done;
  logic [DATA_W-1:0]   r_i;
  logic [CODE_W-1:0]   r_out_a_sel, r_out_b_sel, r_fun_sel;
  logic [3:0]          r_reg_sel, r_scr_sel;

  logic                w_accept;
  logic [1:0]          w_op;
  logic [CODE_W-1:0]   w_src, w_dst;
  logic [DATA_W-1:0]   w_data, w_hold_a, w_hold_b;
  logic                w_ready_nxt, w_done_nxt;
  logic [DATA_W-1:0]   w_i_nxt;
  logic [CODE_W-1:0]   w_a_sel_nxt, w_b_sel_nxt;
  logic [EN_W-1:0]     w_en_nxt;

  // Register code to one-hot {RegSel, ScrSel}: code c drives bit (7-c).
  function automatic logic [EN_W-1:0] decode(input logic [CODE_W-1:0] c);
    return EN_W'(8'h80 >> c);
  endfunction

  // Next state plus lookahead of the registered outputs for that state.
  always_comb begin
    w_accept = (r_state == S_IDLE) && i_cmd_valid;
    w_op     = w_accept ? i_cmd_op   : r_op;
    w_src    = w_accept ? i_cmd_src  : r_src;
    w_dst    = w_accept ? i_cmd_dst  : r_dst;
    w_data   = w_accept ? i_cmd_data : r_data;
    w_hold_a = (r_state == S_RD) ? i_out_a : r_hold_a;
    w_hold_b = (r_state == S_RD) ? i_out_b : r_hold_b;

    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = (i_cmd_op == OP_WRITE) ? S_WR_A : S_RD;
      S_RD:   w_state_next = (r_op == OP_READ) ? S_FIN : S_WR_A;
      S_WR_A: w_state_next = (r_op == OP_SWAP) ? S_WR_B : S_FIN;
      S_WR_B: w_state_next = S_FIN;
      S_FIN:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    w_ready_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_i_nxt     = '0;
    w_a_sel_nxt = '0;
    w_b_sel_nxt = '0;
    w_en_nxt    = '0;
    case (w_state_next)
      S_IDLE: w_ready_nxt = 1'b1;
      S_RD: begin
        w_a_sel_nxt = w_src;
        w_b_sel_nxt = w_dst;
      end
      S_WR_A: begin
        case (w_op)
          OP_WRITE: w_i_nxt = w_data;
          OP_MOVE:  w_i_nxt = w_hold_a;
          default:  w_i_nxt = w_hold_b;
        endcase
        w_en_nxt = decode((w_op == OP_SWAP) ? w_src : w_dst);
      end
      S_WR_B: begin
        w_i_nxt  = w_hold_a;
        w_en_nxt = decode(w_dst);
      end
      S_FIN:  w_done_nxt = 1'b1;
      default: w_ready_nxt = 1'b0;
    endcase
  end

  // State, command latch, hold registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_WRITE;
      r_src       <= '0;
      r_dst       <= '0;
      r_data      <= '0;
      r_hold_a    <= '0;
      r_hold_b    <= '0;
      r_rd_data   <= '0;
      r_cmd_ready <= 1'b1;
      r_done      <= 1'b0;
      r_i         <= '0;
      r_out_a_sel <= '0;
      r_out_b_sel <= '0;
      r_fun_sel   <= FUN_LOAD;
      r_reg_sel   <= '0;
      r_scr_sel   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op   <= i_cmd_op;
        r_src  <= i_cmd_src;
        r_dst  <= i_cmd_dst;
        r_data <= i_cmd_data;
      end
      if (r_state == S_RD) begin
        r_hold_a <= i_out_a;
        r_hold_b <= i_out_b;
        if (r_op == OP_READ) r_rd_data <= i_out_a;
      end
      r_cmd_ready <= w_ready_nxt;
      r_done      <= w_done_nxt;
      r_i         <= w_i_nxt;
      r_out_a_sel <= w_a_sel_nxt;
      r_out_b_sel <= w_b_sel_nxt;
      r_fun_sel   <= FUN_LOAD;
      r_reg_sel   <= w_en_nxt[7:4];
      r_scr_sel   <= w_en_nxt[3:0];
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_done      = r_done;
  assign o_rd_data   = r_rd_data;
  assign o_i         = r_i;
  assign o_out_a_sel = r_out_a_sel;
  assign o_out_b_sel = r_out_b_sel;
  assign o_fun_sel   = r_fun_sel;
  assign o_reg_sel   = r_reg_sel;
  assign o_scr_sel   = r_scr_sel;

endmodule

// File: tb/tb_rf_sequencer.sv
// tb_rf_sequencer: drives command vectors against a behavioural register file,
// predicts results with a reference copy of the file and scores them on Done.
module tb_rf_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_src, cmd_dst;
  logic [31:0] cmd_data;
  logic        done;
  logic [31:0] rd_data, i_bus;
  logic [2:0]  out_a_sel, out_b_sel, fun_sel;
  logic [3:0]  reg_sel, scr_sel;
  logic [31:0] out_a, out_b;
  logic [7:0]  en;

  always #5 clk = ~clk;

  rf_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_src(cmd_src), .i_cmd_dst(cmd_dst), .i_cmd_data(cmd_data),
    .o_done(done), .o_rd_data(rd_data), .o_i(i_bus),
    .o_out_a_sel(out_a_sel), .o_out_b_sel(out_b_sel), .o_fun_sel(fun_sel),
    .o_reg_sel(reg_sel), .o_scr_sel(scr_sel), .i_out_a(out_a), .i_out_b(out_b)
  );

  // Behavioural register file: index 0-3 = R1-R4, 4-7 = S1-S4.
  logic [31:0] rf [8] = '{default: 32'h0};
  assign en    = {reg_sel, scr_sel};
  assign out_a = rf[out_a_sel];
  assign out_b = rf[out_b_sel];
  always @(posedge clk)
    if (fun_sel == 3'b010)
      for (int k = 0; k < 8; k++)
        if (en[7-k]) rf[k] <= i_bus;

  localparam logic [1:0] OP_WRITE = 2'b00, OP_READ = 2'b01, OP_MOVE = 2'b10, OP_SWAP = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  src, dst;
    logic [31:0] data;
    int          lat;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  src, dst;
    logic [31:0] wdata, sval, dval, rd;
    int          lat, nwr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_rf [8];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predict, push to scoreboard, drive one command and score it on Done.
  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t h;
    int   nw;
    bit   got;
    logic [31:0] a, b;
    e.op = v.op; e.src = v.src; e.dst = v.dst; e.wdata = v.data;
    e.lat = v.lat; e.rd = v.rd;
    a = ref_rf[v.src]; b = ref_rf[v.dst];
    case (v.op)
      OP_WRITE: begin ref_rf[v.dst] = v.data; e.nwr = 1; end
      OP_READ:  e.nwr = 0;
      OP_MOVE:  begin ref_rf[v.dst] = a; e.nwr = 1; end
      default:  begin ref_rf[v.src] = b; ref_rf[v.dst] = a; e.nwr = 2; end
    endcase
    e.sval = ref_rf[v.src]; e.dval = ref_rf[v.dst];
    sb.push_back(e);

    @(negedge clk);
    chk("ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_src = v.src; cmd_dst = v.dst; cmd_data = v.data;
    @(posedge clk);
    nw = 0; got = 0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_src = 3'($urandom); cmd_dst = 3'($urandom);
        cmd_data = $urandom;
      end
      chk("fun_sel", 32'(fun_sel), 32'd2);
      chk("en_onehot0", 32'($countones(en) <= 1), 32'd1);
      chk("ready_busy", 32'(cmd_ready), 32'd0);
      if (en != 8'h0) begin
        nw++;
        if (sb[0].op == OP_WRITE) begin
          chk("wr_i", i_bus, sb[0].wdata);
          chk("wr_en", 32'(en), 32'(8'h80 >> sb[0].dst));
        end
      end
      if (done) begin
        got = 1;
        h = sb.pop_front();
        chk("latency", 32'(c), 32'(h.lat));
        chk("rd_data", rd_data, h.rd);
        chk("n_writes", 32'(nw), 32'(h.nwr));
        chk("rf_src", rf[h.src], h.sval);
        chk("rf_dst", rf[h.dst], h.dval);
      end
    end
    if (!got) begin
      void'(sb.pop_front());
      chk("done_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_rd"},    rd_data, 32'h0);
    chk({tag, "_i"},     i_bus, 32'h0);
    chk({tag, "_sels"},  32'({out_a_sel, out_b_sel}), 32'h0);
    chk({tag, "_fun"},   32'(fun_sel), 32'd2);
    chk({tag, "_en"},    32'(en), 32'h0);
  endtask

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{OP_WRITE, 3'd0, 3'd0, 32'h12345678, 2, 32'h0};
    vecs[1]  = '{OP_WRITE, 3'd0, 3'd1, 32'h56781234, 2, 32'h0};
    vecs[2]  = '{OP_WRITE, 3'd0, 3'd5, 32'h34567890, 2, 32'h0};
    vecs[3]  = '{OP_READ,  3'd0, 3'd3, 32'h0,        2, 32'h12345678};
    vecs[4]  = '{OP_MOVE,  3'd1, 3'd6, 32'h0,        3, 32'h12345678};
    vecs[5]  = '{OP_WRITE, 3'd0, 3'd0, 32'hAAAA0001, 2, 32'h12345678};
    vecs[6]  = '{OP_WRITE, 3'd0, 3'd7, 32'hBBBB0002, 2, 32'h12345678};
    vecs[7]  = '{OP_SWAP,  3'd0, 3'd7, 32'h0,        4, 32'h12345678};
    vecs[8]  = '{OP_READ,  3'd7, 3'd0, 32'h0,        2, 32'hAAAA0001};
    vecs[9]  = '{OP_READ,  3'd0, 3'd0, 32'h0,        2, 32'hBBBB0002};
    vecs[10] = '{OP_MOVE,  3'd5, 3'd5, 32'h0,        3, 32'hBBBB0002};
    vecs[11] = '{OP_SWAP,  3'd6, 3'd6, 32'h0,        4, 32'hBBBB0002};
    vecs[12] = '{OP_READ,  3'd6, 3'd1, 32'h0,        2, 32'h56781234};
    vecs[13] = '{OP_READ,  3'd5, 3'd1, 32'h0,        2, 32'h34567890};
    vecs[14] = '{OP_READ,  3'd1, 3'd1, 32'h0,        2, 32'h56781234};
    for (int k = 0; k < 8; k++) ref_rf[k] = 32'h0;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b0; cmd_src = 3'b0; cmd_dst = 3'b0; cmd_data = 32'h0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b0;

    for (int n = 0; n < 15; n++) run_vec(vecs[n]);

    // Reset during WR_A of a SWAP: no further writes, S4 untouched.
    run_vec('{OP_WRITE, 3'd0, 3'd0, 32'hAAAA0001, 2, 32'h56781234});
    run_vec('{OP_WRITE, 3'd0, 3'd7, 32'hBBBB0002, 2, 32'h56781234});
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_SWAP; cmd_src = 3'd0; cmd_dst = 3'd7;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rd_asel", 32'(out_a_sel), 32'd0);
    chk("rd_bsel", 32'(out_b_sel), 32'd7);
    @(negedge clk);
    chk("swap_wra_en", 32'(en), 32'h80);
    chk("swap_wra_i", i_bus, 32'hBBBB0002);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid_rst");
    chk("mid_rst_s4", rf[7], 32'hBBBB0002);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_en", 32'(en), 32'h0);
      chk("post_rst_done", 32'(done), 32'd0);
    end
    chk("post_rst_s4", rf[7], 32'hBBBB0002);
    ref_rf[0] = rf[0];

    // Reset wins over acceptance on the same edge.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_dst = 3'd2; cmd_data = 32'hDEADBEEF;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("prio_ready", 32'(cmd_ready), 32'd1);
      chk("prio_en", 32'(en), 32'h0);
    end
    chk("prio_r3", rf[2], 32'h0);

    // CmdValid held high across two WRITEs.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_dst = 3'd2; cmd_data = 32'h11112222;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_wra_ready", 32'(cmd_ready), 32'd0);
    chk("b2b_wra_en", 32'(en), 32'h20);
    cmd_dst = 3'd3; cmd_data = 32'h33334444;
    @(negedge clk);
    chk("b2b_fin_done", 32'(done), 32'd1);
    chk("b2b_fin_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("b2b_idle_ready", 32'(cmd_ready), 32'd1);
    chk("b2b_idle_done", 32'(done), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_wra2_ready", 32'(cmd_ready), 32'd0);
    chk("b2b_wra2_en", 32'(en), 32'h10);
    chk("b2b_wra2_i", i_bus, 32'h33334444);
    @(negedge clk);
    chk("b2b_fin2_done", 32'(done), 32'd1);
    chk("b2b_r3", rf[2], 32'h11112222);
    chk("b2b_r4", rf[3], 32'h33334444);
    ref_rf[2] = 32'h11112222; ref_rf[3] = 32'h33334444;

    run_vec('{OP_READ, 3'd3, 3'd0, 32'h0, 2, 32'h33334444});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

endmodule
